// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receive controller.
package sipo_pkg;

    // Controller FSM encoding: waiting for a frame start, or clocking bits in.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Default number of bits per frame.
    localparam int SIPO_W = 4;

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit shift register with enable; the bit order of the word is selectable.
module sipo_shift_en
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_srNext;

    // With MSB_FIRST the oldest bit walks up to the top; otherwise it walks down to bit 0.
    generate
        if (MSB_FIRST) begin : g_msbFirst
            assign w_srNext = {r_sr[WIDTH-2:0], serial_in};
        end else begin : g_lsbFirst
            assign w_srNext = {serial_in, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // Shift one bit per enabled cycle; reset clears any partially received word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (en) begin
            r_sr <= w_srNext;
        end
    end

    assign parallel_out = r_sr;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: detects a frame start, shifts exactly WIDTH bits into the
// SIPO, then hands the word to a valid/ready holding register. The serial side
// cannot be stalled, so a word that finds the holding register still full is
// dropped and recorded in a sticky overrun flag.
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             start,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic             shift_en,
    output logic             busy,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CW-1:0]    r_bitCnt;
    logic [CW-1:0]    w_bitCntNext;
    logic             w_shiftEn;
    logic             w_wordDone;
    logic [WIDTH-1:0] w_srOut;
    logic [WIDTH-1:0] w_wordNext;
    logic [WIDTH-1:0] r_wordOut;
    logic             r_wordValid;
    logic             r_overrun;
    logic             w_handshake;
    logic             w_dropWord;

    sipo_shift_en #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .en           (w_shiftEn),
        .serial_in    (serial_in),
        .parallel_out (w_srOut)
    );

    // The finished word must include the bit arriving in the final cycle, so it is
    // formed here from the register contents plus the current serial bit.
    generate
        if (MSB_FIRST) begin : g_wordMsb
            assign w_wordNext = {w_srOut[WIDTH-2:0], serial_in};
        end else begin : g_wordLsb
            assign w_wordNext = {serial_in, w_srOut[WIDTH-1:1]};
        end
    endgenerate

    // FSM and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_bitCnt <= w_bitCntNext;
        end
    end

    // Next-state logic: the start cycle carries bit 0, and start is ignored mid-frame.
    always_comb begin
        w_stateNext  = r_state;
        w_bitCntNext = r_bitCnt;
        w_shiftEn    = 1'b0;
        w_wordDone   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_shiftEn    = 1'b1;
                    w_bitCntNext = CW'(1);
                    w_stateNext  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shiftEn = 1'b1;
                if (r_bitCnt == LAST_BIT) begin
                    w_wordDone   = 1'b1;
                    w_bitCntNext = '0;
                    w_stateNext  = ST_IDLE;
                end else begin
                    w_bitCntNext = r_bitCnt + CW'(1);
                end
            end
            default: begin
                w_stateNext  = ST_IDLE;
                w_bitCntNext = '0;
            end
        endcase
    end

    assign w_handshake = r_wordValid && out_ready;
    assign w_dropWord  = w_wordDone && r_wordValid && !out_ready;

    // Holding register: load a finished word when empty or being drained this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wordOut   <= '0;
            r_wordValid <= 1'b0;
        end else if (w_wordDone && (!r_wordValid || out_ready)) begin
            r_wordOut   <= w_wordNext;
            r_wordValid <= 1'b1;
        end else if (w_handshake) begin
            r_wordValid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_dropWord) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign shift_en   = w_shiftEn;
    assign busy       = (r_state == ST_SHIFT);
    assign word_out   = r_wordOut;
    assign word_valid = r_wordValid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl. Two instances share all inputs: one
// receives MSB first, the other LSB first. Expected words are queued when a
// frame is driven and compared whenever a DUT completes a handshake.
module tb_sipo_rx_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         start;
    logic         out_ready;
    logic         clr_ovr;

    logic         mShiftEn, mBusy, mValid, mOverrun;
    logic [W-1:0] mWord;
    logic         lShiftEn, lBusy, lValid, lOverrun;
    logic [W-1:0] lWord;

    int           vectors     = 0;
    int           miscompares = 0;

    logic [W-1:0] qMsb[$];
    logic [W-1:0] qLsb[$];

    sipo_rx_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .start      (start),
        .out_ready  (out_ready),
        .clr_ovr    (clr_ovr),
        .shift_en   (mShiftEn),
        .busy       (mBusy),
        .word_out   (mWord),
        .word_valid (mValid),
        .overrun    (mOverrun)
    );

    sipo_rx_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .start      (start),
        .out_ready  (out_ready),
        .clr_ovr    (clr_ovr),
        .shift_en   (lShiftEn),
        .busy       (lBusy),
        .word_out   (lWord),
        .word_valid (lValid),
        .overrun    (lOverrun)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Bit-reversal of the sent sequence gives the LSB-first word.
    function automatic logic [W-1:0] reverseBits(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_shiftEn"}, {mShiftEn, lShiftEn}, 2'b00);
        checkOutput({tag, "_busy"},    {mBusy, lBusy},       2'b00);
        checkOutput({tag, "_valid"},   {mValid, lValid},     2'b00);
        checkOutput({tag, "_overrun"}, {mOverrun, lOverrun}, 2'b00);
        checkOutput({tag, "_word"},    {mWord, lWord},       8'h00);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; seq[W-1] is sent first. Optionally re-pulse start mid-frame.
    task automatic applyStimulus(input logic [W-1:0] seq, input bit pushExpect, input bit midStart);
        if (pushExpect) begin
            qMsb.push_back(seq);
            qLsb.push_back(reverseBits(seq));
        end
        for (int i = 0; i < W; i++) begin
            start     = (i == 0) || (midStart && (i == 2));
            serial_in = seq[W-1-i];
            @(negedge clk);
            checkOutput("frameShiftEn", {mShiftEn, lShiftEn}, 2'b11);
            checkOutput("frameBusy", {31'd0, mBusy}, {31'd0, i != 0});
            nextCycle();
        end
        start     = 1'b0;
        serial_in = 1'b0;
    endtask

    // Scoreboard: every completed handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && mValid && out_ready) begin
            if (qMsb.size() == 0) checkOutput("msbUnexpectedWord", {28'd0, mWord}, 32'hFFFF_FFFF);
            else                  checkOutput("msbWord", {28'd0, mWord}, {28'd0, qMsb.pop_front()});
        end
        if (!rst && lValid && out_ready) begin
            if (qLsb.size() == 0) checkOutput("lsbUnexpectedWord", {28'd0, lWord}, 32'hFFFF_FFFF);
            else                  checkOutput("lsbWord", {28'd0, lWord}, {28'd0, qLsb.pop_front()});
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b1;
        clr_ovr   = 1'b0;

        // Reset for two cycles, then idle with no start.
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idleShiftEn", {mShiftEn, lShiftEn}, 2'b00);
            nextCycle();
        end

        // Single frame 1,0,0,1 with the consumer ready.
        applyStimulus(4'b1001, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("singleValid", {mValid, lValid}, 2'b11);
        checkOutput("singleWord", {28'd0, mWord}, 32'h9);
        checkOutput("singleShiftEnOff", {mShiftEn, mBusy}, 2'b00);
        nextCycle();
        @(negedge clk);
        checkOutput("singleValidDrop", {mValid, lValid}, 2'b00);
        nextCycle();

        // Back-to-back frames with zero gap.
        applyStimulus(4'b1100, 1'b1, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("b2bWord", {28'd0, mWord}, 32'h5);
        checkOutput("b2bOverrun", {mOverrun, lOverrun}, 2'b00);
        nextCycle();

        // Overrun: consumer stalled, second frame dropped.
        out_ready = 1'b0;
        applyStimulus(4'b1010, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ovrBefore", {mOverrun, lOverrun}, 2'b00);
        nextCycle();
        applyStimulus(4'b0111, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ovrSet", {mOverrun, lOverrun}, 2'b11);
        checkOutput("ovrKeepWord", {28'd0, mWord}, 32'hA);
        checkOutput("ovrValid", {mValid, lValid}, 2'b11);
        nextCycle();

        // Clear held during a frame whose last bit drops again: set must win.
        clr_ovr = 1'b1;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        clr_ovr = 1'b0;
        @(negedge clk);
        checkOutput("ovrSetWins", {mOverrun, lOverrun}, 2'b11);
        checkOutput("ovrSetWinsWord", {28'd0, mWord}, 32'hA);
        nextCycle();

        // Plain clear.
        clr_ovr = 1'b1;
        nextCycle();
        clr_ovr = 1'b0;
        @(negedge clk);
        checkOutput("ovrCleared", {mOverrun, lOverrun}, 2'b00);
        checkOutput("ovrStillValid", {mValid, lValid}, 2'b11);
        nextCycle();

        // Consumer becomes ready: held word drains, valid drops next cycle.
        out_ready = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("drainValidDrop", {mValid, lValid}, 2'b00);
        nextCycle();

        // Reset in the middle of a frame.
        start     = 1'b1;
        serial_in = 1'b1;
        nextCycle();
        start     = 1'b0;
        serial_in = 1'b1;
        nextCycle();
        checkOutput("midBusy", {mBusy, lBusy}, 2'b11);
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        nextCycle();
        rst = 1'b0;
        applyStimulus(4'b0011, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("afterResetWord", {28'd0, mWord}, 32'h3);
        nextCycle();

        // Reset while a word is held: word lost, no overrun.
        out_ready = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("heldBeforeReset", {mValid, lValid}, 2'b11);
        rst = 1'b1;
        #1;
        checkAllZero("heldReset");
        nextCycle();
        rst       = 1'b0;
        out_ready = 1'b1;

        // Start re-pulsed mid-frame is ignored; frame is still four bits.
        applyStimulus(4'b1000, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("frameLenBusy", {mBusy, lBusy}, 2'b00);
        checkOutput("frameLenShiftEn", {mShiftEn, lShiftEn}, 2'b00);
        checkOutput("lsbFirstWord", {28'd0, lWord}, 32'h1);
        checkOutput("msbFirstWord", {28'd0, mWord}, 32'h8);
        nextCycle();

        repeat (2) nextCycle();
        checkOutput("msbQueueEmpty", qMsb.size(), 32'd0);
        checkOutput("lsbQueueEmpty", qLsb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Frame controller that sequences a serial-in/parallel-out shift register.
- Detects a frame start and drives shift-enable for exactly WIDTH bits.
- Transfers each completed word into an output holding register with a valid/ready handshake.
- Sits between a raw serial line and a parallel consumer; the serial side cannot stall, so lost words are flagged as overrun.

Parameters:
- WIDTH, 4, bits per frame (>=2).
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- serial_in  input  1  serial data, sampled every clk edge while receiving
- start  input  1  frame-start strobe; the serial_in bit in the same cycle is bit 0
- out_ready  input  1  consumer accepts word_out when word_valid=1
- clr_ovr  input  1  clears the sticky overrun flag
- shift_en  output  1  high in every cycle a bit is shifted into the internal SIPO
- busy  output  1  high while in the SHIFT state
- word_out  output  WIDTH  holding register, stable while word_valid=1
- word_valid  output  1  holding register contains an unconsumed word
- overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, bit_cnt=0, shift register=0.
  - word_out=0, word_valid=0, overrun=0, busy=0, shift_en=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - shift_en=start.
  - If start=1: shift in serial_in, bit_cnt<=1, go to SHIFT.
- SHIFT:
  - shift_en=1 every cycle; shift in serial_in; bit_cnt increments.
  - When bit_cnt==WIDTH-1, the current bit is the last one: bit_cnt<=0, go to IDLE, and the completed word (including the current bit) goes to the holding logic.
- start while in SHIFT is ignored; no restart and no error.
- Shift rule:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sr <= {serial_in, sr[WIDTH-1:1]}.
- Latency: start at cycle 0 means the last bit is sampled at cycle WIDTH-1, and word_valid=1 from cycle WIDTH.
- Back-to-back frames: start may be asserted in cycle WIDTH (the first IDLE cycle), giving zero gap.
- Holding register:
  - Handshake completes when word_valid && out_ready; word_valid then drops next cycle unless a new word completes in that same cycle.
  - Word completes and the holding register is empty or being consumed this cycle: word_out<=new word, word_valid<=1.
  - Word completes, word_valid=1 and out_ready=0: new word is dropped, word_out keeps the old value, overrun<=1.
- Overrun:
  - overrun stays set until clr_ovr=1.
  - If clr_ovr and a new overrun event occur in the same cycle, set wins.
- busy = (state==SHIFT).
- bit_cnt width is $clog2(WIDTH); it never exceeds WIDTH-1.
- Reset mid-frame: partial word discarded, all outputs return to reset values immediately.
- Reset while word_valid=1: word is lost, no overrun recorded.

Decomposition:
- Shared package sipo_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the default frame width constant SIPO_W=4.
- Sub-module sipo_shift_en: WIDTH-bit shift register.
  - Ports: clk, rst, en, serial_in, parallel_out; parameter MSB_FIRST.
  - Instanced once inside sipo_rx_ctrl.
- The controller keeps the FSM, bit counter, holding register and overrun logic.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, busy=0; then rst=0 with start=0 for 5 cycles -> shift_en never asserts.
- Single frame: WIDTH=4, MSB_FIRST=1, start=1 with serial_in 1,0,0,1 over cycles 0-3, out_ready=1 -> word_out=4'b1001, word_valid=1 in cycle 4 for one cycle, shift_en high in cycles 0-3 only.
- Back-to-back: frame 1,1,0,0 then start again in cycle 4 with 0,1,0,1 -> word_out=4'b1100 at cycle 4, 4'b0101 at cycle 8, no overrun.
- Overrun: out_ready=0, frames 1,0,1,0 then 0,1,1,1 -> word_out stays 4'b1010, overrun=1 from cycle 9. Then clr_ovr=1 -> overrun=0. Then out_ready=1 -> word_valid drops next cycle.
- Reset mid-frame: start with 1,1 then rst=1 at cycle 2 -> busy=0 immediately; new frame 0,0,1,1 -> word_out=4'b0011.
- LSB-first: MSB_FIRST=0, serial_in 1,0,0,0 -> word_out=4'b0001; a start pulse mid-frame is ignored, so the frame length stays 4.
